ram_arbiter: RTL

- Two-requester arbiter and sequencer for the 32-word x 32-bit data RAM.
- Lets the core data port (m0) and a debug/loader port (m1) share the single RAM command interface (readWrite/address/dataIN/dataOUT).
- Each requester uses a req/ack handshake. Arbitration is round-robin, or fixed priority for m0 when configured.

---
 rtl/ram_arbiter_if.sv | 16 +
 rtl/ram_arbiter.sv | 111 +++++++++++
 2 files changed

// File: rtl/ram_arbiter_if.sv
// Requester-side req/ack bundle for one port of the data-RAM arbiter.
// The requester holds req and its fields stable until it sees a one-cycle ack.
interface ram_arbiter_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ack;
   logic [DATA_W-1:0] rdata;

   modport master (output req, we, addr, wdata, input ack, rdata);
   modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester arbiter/sequencer for the single-port data RAM.
// Every grant takes three cycles: IDLE (sample req) -> ISSUE (RAM command) -> RESP (ack).
module ram_arbiter #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter bit          FIX_PRIO = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   ram_arbiter_if.slave      m0,
   ram_arbiter_if.slave      m1,
   output logic              ram_readWrite,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_dataIN,
   input  logic [DATA_W-1:0] ram_dataOUT,
   output logic              busy
);

   typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

   state_e            state_q, state_d;
   logic              gnt_q, gnt_d;    // 0 = m0, 1 = m1
   logic              last_q, last_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic              pick;

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      last_d   = last_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      pick     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (m0.req && m1.req) begin
               pick = FIX_PRIO ? 1'b0 : ~last_q;
            end else begin
               pick = m1.req;
            end
            if (m0.req || m1.req) begin
               gnt_d   = pick;
               last_d  = pick;
               we_d    = pick ? m1.we    : m0.we;
               addr_d  = pick ? m1.addr  : m0.addr;
               wdata_d = pick ? m1.wdata : m0.wdata;
               state_d = StIssue;
            end
         end
         StIssue: begin
            // RAM read data is captured on the edge into RESP so it is valid with ack.
            if (!we_q) begin
               if (gnt_q) begin
                  rdata1_d = ram_dataOUT;
               end else begin
                  rdata0_d = ram_dataOUT;
               end
            end
            state_d = StResp;
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         gnt_q    <= 1'b0;
         last_q   <= 1'b1;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         last_q   <= last_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   // Strobe and acks decode from state only, so reset kills them without waiting for a clock.
   assign ram_readWrite = (state_q == StIssue) && we_q;
   assign ram_address   = addr_q;
   assign ram_dataIN    = wdata_q;
   assign busy          = (state_q != StIdle);

   assign m0.ack   = (state_q == StResp) && !gnt_q;
   assign m1.ack   = (state_q == StResp) &&  gnt_q;
   assign m0.rdata = rdata0_q;
   assign m1.rdata = rdata1_q;

endmodule
